// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: bridge FSM states, burst/response encodings, field helpers.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AxSIZE encoding for a beat of data_w bits.
    function automatic logic [2:0] size_of(input int unsigned data_w);
        case (data_w)
            8:       return 3'd0;
            16:      return 3'd1;
            32:      return 3'd2;
            64:      return 3'd3;
            128:     return 3'd4;
            256:     return 3'd5;
            512:     return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    // SLVERR and DECERR both report as an error; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic r_is_err;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   r_is_err = 1'b0;
            RESP_SLVERR, RESP_DECERR: r_is_err = 1'b1;
            default:                  r_is_err = 1'b0;
        endcase
        return r_is_err;
    endfunction

endpackage

// File: rtl/axi_burst.sv
// Native-to-AXI4 master bridge: each accepted request becomes one INCR burst.
module axi_burst
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic                  i_req_instr,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [LEN_W-1:0]      i_req_len,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_strb,
    output logic                  o_rd_valid,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_last,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_m_axi_awvalid,
    input  logic                  i_m_axi_awready,
    output logic [ADDR_W-1:0]     o_m_axi_awaddr,
    output logic [7:0]            o_m_axi_awlen,
    output logic [2:0]            o_m_axi_awsize,
    output logic [1:0]            o_m_axi_awburst,
    output logic                  o_m_axi_awlock,
    output logic [3:0]            o_m_axi_awcache,
    output logic [2:0]            o_m_axi_awprot,
    output logic [3:0]            o_m_axi_awqos,
    output logic                  o_m_axi_wvalid,
    input  logic                  i_m_axi_wready,
    output logic [DATA_W-1:0]     o_m_axi_wdata,
    output logic [DATA_W/8-1:0]   o_m_axi_wstrb,
    output logic                  o_m_axi_wlast,
    input  logic                  i_m_axi_bvalid,
    output logic                  o_m_axi_bready,
    input  logic [1:0]            i_m_axi_bresp,
    output logic                  o_m_axi_arvalid,
    input  logic                  i_m_axi_arready,
    output logic [ADDR_W-1:0]     o_m_axi_araddr,
    output logic [7:0]            o_m_axi_arlen,
    output logic [2:0]            o_m_axi_arsize,
    output logic [1:0]            o_m_axi_arburst,
    output logic                  o_m_axi_arlock,
    output logic [3:0]            o_m_axi_arcache,
    output logic [2:0]            o_m_axi_arprot,
    output logic [3:0]            o_m_axi_arqos,
    input  logic                  i_m_axi_rvalid,
    output logic                  o_m_axi_rready,
    input  logic [DATA_W-1:0]     i_m_axi_rdata,
    input  logic [1:0]            i_m_axi_rresp,
    input  logic                  i_m_axi_rlast
);

    localparam int unsigned NB = DATA_W / 8;

    state_t              r_state,    w_state;
    logic                r_req_ready, w_req_ready;
    logic [ADDR_W-1:0]   r_addr,     w_addr;
    logic [LEN_W-1:0]    r_len,      w_len;
    logic [2:0]          r_prot,     w_prot;
    logic [2:0]          r_size,     w_size;
    logic [1:0]          r_burst,    w_burst;
    logic                r_arvalid,  w_arvalid;
    logic                r_rready,   w_rready;
    logic                r_awvalid,  w_awvalid;
    logic                r_bready,   w_bready;
    logic                r_wvalid,   w_wvalid;
    logic [DATA_W-1:0]   r_wdata,    w_wdata;
    logic [NB-1:0]       r_wstrb,    w_wstrb;
    logic                r_wlast,    w_wlast;
    logic                r_w_done,   w_w_done;
    logic [LEN_W:0]      r_cnt,      w_cnt;
    logic                r_rd_valid, w_rd_valid;
    logic [DATA_W-1:0]   r_rd_data,  w_rd_data;
    logic                r_rd_last,  w_rd_last;
    logic                r_done,     w_done;
    logic                r_err,      w_err;

    logic w_req_hs, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_wr_hs;
    logic w_beats_left, w_wr_ready;

    assign w_req_hs     = i_req_valid & r_req_ready;
    assign w_ar_hs      = r_arvalid & i_m_axi_arready;
    assign w_r_hs       = i_m_axi_rvalid & r_rready;
    assign w_aw_hs      = r_awvalid & i_m_axi_awready;
    assign w_w_hs       = r_wvalid & i_m_axi_wready;
    assign w_b_hs       = i_m_axi_bvalid & r_bready;
    // Counter is one bit wider than len so it saturates at len+1 instead of wrapping.
    assign w_beats_left = (r_cnt <= {1'b0, r_len});
    assign w_wr_ready   = (r_state == WRITE) & w_beats_left & (~r_wvalid | i_m_axi_wready);
    assign w_wr_hs      = i_wr_valid & w_wr_ready;

    // Next-state and next-output computation for the whole bridge.
    always_comb begin
        w_state     = r_state;
        w_req_ready = r_req_ready;
        w_addr      = r_addr;
        w_len       = r_len;
        w_prot      = r_prot;
        w_size      = r_size;
        w_burst     = r_burst;
        w_arvalid   = r_arvalid;
        w_rready    = r_rready;
        w_awvalid   = r_awvalid;
        w_bready    = r_bready;
        w_wvalid    = r_wvalid;
        w_wdata     = r_wdata;
        w_wstrb     = r_wstrb;
        w_wlast     = r_wlast;
        w_w_done    = r_w_done;
        w_cnt       = r_cnt;
        w_rd_valid  = 1'b0;
        w_rd_data   = r_rd_data;
        w_rd_last   = 1'b0;
        w_done      = 1'b0;
        w_err       = r_err;

        unique case (r_state)
            IDLE: begin
                if (w_req_hs) begin
                    w_addr      = i_req_addr & ~ADDR_W'(NB - 1);
                    w_len       = i_req_len;
                    w_prot      = {i_req_instr, 2'b00};
                    w_size      = size_of(DATA_W);
                    w_burst     = BURST_INCR;
                    w_err       = 1'b0;
                    w_cnt       = '0;
                    w_w_done    = 1'b0;
                    w_wlast     = 1'b0;
                    w_req_ready = 1'b0;
                    if (i_req_write) begin
                        w_state   = WRITE;
                        w_awvalid = 1'b1;
                    end else begin
                        w_state   = READ;
                        w_arvalid = 1'b1;
                        w_rready  = 1'b1;
                    end
                end
            end
            READ: begin
                if (w_ar_hs) w_arvalid = 1'b0;
                if (w_r_hs) begin
                    w_rd_valid = 1'b1;
                    w_rd_data  = i_m_axi_rdata;
                    w_rd_last  = i_m_axi_rlast;
                    w_err      = r_err | resp_is_err(i_m_axi_rresp);
                    if (i_m_axi_rlast) begin
                        w_state     = IDLE;
                        w_rready    = 1'b0;
                        w_done      = 1'b1;
                        w_req_ready = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (w_aw_hs) w_awvalid = 1'b0;
                if (w_w_hs) w_wvalid = 1'b0;
                if (w_w_hs && r_wlast) w_w_done = 1'b1;
                if (w_wr_hs) begin
                    w_wvalid = 1'b1;
                    w_wdata  = i_wr_data;
                    w_wstrb  = i_wr_strb;
                    w_wlast  = (r_cnt[LEN_W-1:0] == r_len);
                    w_cnt    = r_cnt + 1'b1;
                end
                if (w_b_hs) begin
                    w_state     = IDLE;
                    w_bready    = 1'b0;
                    w_done      = 1'b1;
                    w_err       = resp_is_err(i_m_axi_bresp);
                    w_req_ready = 1'b1;
                end else begin
                    // B is only opened once AW is accepted and the last W beat has gone out.
                    w_bready = (~r_awvalid | w_aw_hs) & (r_w_done | (w_w_hs & r_wlast));
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_addr      <= '0;
            r_len       <= '0;
            r_prot      <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wlast     <= 1'b0;
            r_w_done    <= 1'b0;
            r_cnt       <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_last   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_req_ready <= w_req_ready;
            r_addr      <= w_addr;
            r_len       <= w_len;
            r_prot      <= w_prot;
            r_size      <= w_size;
            r_burst     <= w_burst;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_awvalid   <= w_awvalid;
            r_bready    <= w_bready;
            r_wvalid    <= w_wvalid;
            r_wdata     <= w_wdata;
            r_wstrb     <= w_wstrb;
            r_wlast     <= w_wlast;
            r_w_done    <= w_w_done;
            r_cnt       <= w_cnt;
            r_rd_valid  <= w_rd_valid;
            r_rd_data   <= w_rd_data;
            r_rd_last   <= w_rd_last;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_wr_ready      = w_wr_ready;
    assign o_rd_valid      = r_rd_valid;
    assign o_rd_data       = r_rd_data;
    assign o_rd_last       = r_rd_last;
    assign o_done          = r_done;
    assign o_err           = r_err;

    assign o_m_axi_awvalid = r_awvalid;
    assign o_m_axi_awaddr  = r_addr;
    assign o_m_axi_awlen   = 8'(r_len);
    assign o_m_axi_awsize  = r_size;
    assign o_m_axi_awburst = r_burst;
    assign o_m_axi_awlock  = 1'b0;
    assign o_m_axi_awcache = 4'd0;
    assign o_m_axi_awprot  = r_prot;
    assign o_m_axi_awqos   = 4'd0;

    assign o_m_axi_wvalid  = r_wvalid;
    assign o_m_axi_wdata   = r_wdata;
    assign o_m_axi_wstrb   = r_wstrb;
    assign o_m_axi_wlast   = r_wlast;
    assign o_m_axi_bready  = r_bready;

    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_araddr  = r_addr;
    assign o_m_axi_arlen   = 8'(r_len);
    assign o_m_axi_arsize  = r_size;
    assign o_m_axi_arburst = r_burst;
    assign o_m_axi_arlock  = 1'b0;
    assign o_m_axi_arcache = 4'd0;
    assign o_m_axi_arprot  = r_prot;
    assign o_m_axi_arqos   = 4'd0;
    assign o_m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_burst.sv
// Directed scoreboard bench for axi_burst (64-bit data, 4-bit length field).
module tb_axi_burst;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned LW = 4;
    localparam int unsigned NB = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid, req_ready, req_write, req_instr;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_strb;
    logic          rd_valid, rd_last, done, err;
    logic [DW-1:0] rd_data;
    logic          awvalid, awready, awlock;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize, awprot;
    logic [1:0]    awburst;
    logic [3:0]    awcache, awqos;
    logic          wvalid, wready, wlast;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          arvalid, arready, arlock;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize, arprot;
    logic [1:0]    arburst;
    logic [3:0]    arcache, arqos;
    logic          rvalid, rready, rlast;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    axi_burst #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_instr(req_instr), .i_req_addr(req_addr), .i_req_len(req_len),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_last(rd_last),
        .o_done(done), .o_err(err),
        .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready), .o_m_axi_awaddr(awaddr),
        .o_m_axi_awlen(awlen), .o_m_axi_awsize(awsize), .o_m_axi_awburst(awburst),
        .o_m_axi_awlock(awlock), .o_m_axi_awcache(awcache), .o_m_axi_awprot(awprot),
        .o_m_axi_awqos(awqos),
        .o_m_axi_wvalid(wvalid), .i_m_axi_wready(wready), .o_m_axi_wdata(wdata),
        .o_m_axi_wstrb(wstrb), .o_m_axi_wlast(wlast),
        .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready), .i_m_axi_bresp(bresp),
        .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready), .o_m_axi_araddr(araddr),
        .o_m_axi_arlen(arlen), .o_m_axi_arsize(arsize), .o_m_axi_arburst(arburst),
        .o_m_axi_arlock(arlock), .o_m_axi_arcache(arcache), .o_m_axi_arprot(arprot),
        .o_m_axi_arqos(arqos),
        .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready), .i_m_axi_rdata(rdata),
        .i_m_axi_rresp(rresp), .i_m_axi_rlast(rlast)
    );

    typedef struct {logic [DW-1:0] data; logic last;} rd_exp_t;
    typedef struct {logic [DW-1:0] data; logic [NB-1:0] strb; logic last;} w_exp_t;

    rd_exp_t q_rd[$];
    w_exp_t  q_w[$];
    logic    q_done[$];

    int total = 0;
    int bad   = 0;
    int n_rd = 0, n_w = 0, n_done = 0;
    int wr_idx = 0, exp_len = 0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic wr_hs_seen, w_hs_seen, b_hs_seen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, DUT outputs 1 time unit after it.
    task automatic tick();
        rd_exp_t er;
        w_exp_t  ew;
        logic    ed;
        #1;
        wr_hs_seen = wr_valid & wr_ready;
        w_hs_seen  = wvalid & wready;
        b_hs_seen  = bvalid & bready;
        if (stall_prev) begin
            chk("w_hold_valid", wvalid, 1);
            chk("w_hold_data", wdata, stall_data);
        end
        stall_prev = wvalid & ~wready;
        stall_data = wdata;
        if (wr_hs_seen) begin
            ew.data = wr_data;
            ew.strb = wr_strb;
            ew.last = (wr_idx == exp_len);
            q_w.push_back(ew);
            wr_idx++;
        end
        if (w_hs_seen) begin
            n_w++;
            if (q_w.size() == 0) chk("w_unexpected", 1, 0);
            else begin
                ew = q_w.pop_front();
                chk("wdata", wdata, ew.data);
                chk("wstrb", wstrb, ew.strb);
                chk("wlast", wlast, ew.last);
            end
        end
        @(posedge clk);
        #1;
        if (rd_valid) begin
            n_rd++;
            if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                er = q_rd.pop_front();
                chk("rd_data", rd_data, er.data);
                chk("rd_last", rd_last, er.last);
            end
        end
        if (done) begin
            n_done++;
            if (q_done.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                ed = q_done.pop_front();
                chk("done_err", err, ed);
            end
        end
    endtask

    task automatic do_req(input logic wr, input logic instr, input logic [AW-1:0] addr,
                          input int len);
        req_valid = 1'b1;
        req_write = wr;
        req_instr = instr;
        req_addr  = addr;
        req_len   = LW'(len);
        exp_len   = len;
        wr_idx    = 0;
        chk("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_instr = 1'b0;
        chk("req_ready_busy", req_ready, 0);
    endtask

    task automatic run_read(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] base);
        int rd0, dn0;
        rd0 = n_rd;
        dn0 = n_done;
        do_req(1'b0, 1'b0, addr, len);
        chk("rr_arlen", arlen, len);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i <= len; i++) begin
            rvalid = 1'b1;
            rdata  = base + DW'(i);
            rlast  = (i == len);
            rresp  = 2'b00;
            q_rd.push_back('{data: base + DW'(i), last: (i == len)});
            if (i == len) q_done.push_back(1'b0);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        tick();
        chk("rr_rd_count", n_rd - rd0, len + 1);
        chk("rr_done_count", n_done - dn0, 1);
    endtask

    // Slave with early bvalid and wready=1; awready held off for aw_delay cycles.
    task automatic run_write(input int len, input logic [1:0] resp, input int aw_delay);
        int w0, dn0, cyc;
        w0  = n_w;
        dn0 = n_done;
        bvalid = 1'b1;
        bresp  = resp;
        wready = 1'b1;
        q_done.push_back(resp[1]);
        for (cyc = 0; cyc < 40; cyc++) begin
            awready  = (cyc >= aw_delay);
            wr_valid = (wr_idx <= exp_len);
            wr_data  = {32'hCAFE_0000 | 32'(wr_idx), 32'h1234_0000 + 32'(cyc)};
            wr_strb  = 8'hF0 ^ 8'(wr_idx);
            tick();
            if (b_hs_seen) break;
            if (cyc < aw_delay) begin
                chk("wr_b_before_aw", b_hs_seen, 0);
                chk("wr_aw_hold", awvalid, 1);
            end
            if (cyc == aw_delay - 1) chk("wr_w_leads_aw", n_w - w0, len + 1);
        end
        chk("wr_b_accepted", b_hs_seen, 1);
        bvalid   = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        wr_valid = 1'b0;
        chk("wr_w_count", n_w - w0, len + 1);
        chk("wr_done_count", n_done - dn0, 1);
        chk("wr_awvalid_low", awvalid, 0);
    endtask

    initial begin
        int rd0, dn0, w0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_instr = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_arburst", arburst, 0);
        rst_n = 1'b1;
        tick();

        // Single-beat read, unaligned address.
        rd0 = n_rd;
        dn0 = n_done;
        do_req(1'b0, 1'b1, 32'h0000_1003, 0);
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h0000_1000);
        chk("t1_arlen", arlen, 0);
        chk("t1_arsize", arsize, 3);
        chk("t1_arburst", arburst, 2'b01);
        chk("t1_arprot", arprot, 3'b100);
        chk("t1_rready", rready, 1);
        chk("t1_awvalid", awvalid, 0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("t1_ar_drop", arvalid, 0);
        rvalid = 1'b1; rdata = 64'hA5A5_0000_1111_2222; rlast = 1'b1; rresp = 2'b00;
        q_rd.push_back('{data: 64'hA5A5_0000_1111_2222, last: 1'b1});
        q_done.push_back(1'b0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        chk("t1_rd_count", n_rd - rd0, 1);
        chk("t1_done_count", n_done - dn0, 1);
        chk("t1_rready_low", rready, 0);
        chk("t1_req_ready", req_ready, 1);
        tick();
        chk("t1_done_pulse", done, 0);

        // Four-beat read, arready delayed, gapped rvalid, busy request ignored.
        rd0 = n_rd;
        dn0 = n_done;
        do_req(1'b0, 1'b0, 32'h0000_2040, 3);
        chk("t2_arlen", arlen, 3);
        chk("t2_arprot", arprot, 3'b000);
        req_valid = 1'b1;
        req_write = 1'b1;
        repeat (3) begin
            tick();
            chk("t2_ar_hold", arvalid, 1);
            chk("t2_busy_ignored", awvalid, 0);
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("t2_ar_drop", arvalid, 0);
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b0;
            tick();
            rvalid = 1'b1;
            rdata  = 64'h0000_BEEF_0000_1000 + DW'(i);
            rlast  = (i == 3);
            q_rd.push_back('{data: 64'h0000_BEEF_0000_1000 + DW'(i), last: (i == 3)});
            if (i == 3) q_done.push_back(1'b0);
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        tick();
        chk("t2_rd_count", n_rd - rd0, 4);
        chk("t2_done_count", n_done - dn0, 1);

        // Eight-beat write with wready toggling 1010...
        w0  = n_w;
        dn0 = n_done;
        do_req(1'b1, 1'b0, 32'h0000_3000, 7);
        chk("t3_awvalid", awvalid, 1);
        chk("t3_awaddr", awaddr, 32'h0000_3000);
        chk("t3_awlen", awlen, 7);
        chk("t3_awsize", awsize, 3);
        chk("t3_awburst", awburst, 2'b01);
        chk("t3_bready_early", bready, 0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("t3_aw_drop", awvalid, 0);
        for (int c = 0; c < 100 && (n_w - w0) < 8; c++) begin
            wready   = (c % 2 == 0);
            wr_valid = (wr_idx < 8);
            wr_data  = {32'hD0D0_0000 + 32'(wr_idx), 32'h5A5A_0000 + 32'(wr_idx)};
            wr_strb  = 8'hFF >> (wr_idx % 4);
            tick();
        end
        wready = 1'b0;
        chk("t3_w_count", n_w - w0, 8);
        wr_valid = 1'b1;
        #1;
        chk("t3_wr_ready_after_last", wr_ready, 0);
        wr_valid = 1'b0;
        chk("t3_wr_beats", wr_idx, 8);
        bvalid = 1'b1;
        bresp  = 2'b00;
        q_done.push_back(1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (b_hs_seen) break;
        end
        bvalid = 1'b0;
        chk("t3_b_accepted", b_hs_seen, 1);
        chk("t3_done_count", n_done - dn0, 1);

        // Write with SLVERR, then a clean read clears err.
        do_req(1'b1, 1'b0, 32'h0000_4008, 0);
        run_write(0, 2'b10, 0);
        chk("t4_err", err, 1);
        run_read(32'h0000_5000, 1, 64'h1111_2222_3333_0000);
        chk("t4_err_cleared", err, 0);

        // W leads AW, bvalid presented early.
        do_req(1'b1, 1'b0, 32'h0000_7000, 1);
        run_write(1, 2'b00, 4);

        // Reset in the middle of a 4-beat read; arready already high at request.
        rd0 = n_rd;
        dn0 = n_done;
        arready = 1'b1;
        do_req(1'b0, 1'b0, 32'h0000_6000, 3);
        chk("t6_arvalid", arvalid, 1);
        tick();
        arready = 1'b0;
        chk("t6_ar_one_cycle", arvalid, 0);
        for (int i = 0; i < 2; i++) begin
            rvalid = 1'b1;
            rdata  = 64'h6666_0000_0000_0000 + DW'(i);
            rlast  = 1'b0;
            q_rd.push_back('{data: 64'h6666_0000_0000_0000 + DW'(i), last: 1'b0});
            tick();
        end
        rst_n = 1'b0;
        repeat (2) tick();
        chk("t6_rd_count", n_rd - rd0, 2);
        chk("t6_arvalid", arvalid, 0);
        chk("t6_rready", rready, 0);
        chk("t6_awvalid", awvalid, 0);
        chk("t6_wvalid", wvalid, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_req_ready", req_ready, 1);
        rvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t6_no_done", n_done - dn0, 0);
        run_read(32'h0000_6100, 1, 64'h7777_0000_0000_0000);

        chk("end_q_rd_empty", q_rd.size(), 0);
        chk("end_q_w_empty", q_w.size(), 0);
        chk("end_q_done_empty", q_done.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
